// File: rtl/truth_table_sequencer.sv
// Drives all 16 input vectors into a 3-output combinational unit, samples each
// output after a settle delay and accumulates per-output truth-table maps and ones-counts.
module truth_table_sequencer #(
  parameter int DWELL_CYCLES  = 25000000,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 25
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic [2:0]  func_in,
  output logic [3:0]  vec_out,
  output logic        vec_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] f1_map,
  output logic [15:0] f2_map,
  output logic [15:0] f3_map,
  output logic [4:0]  f1_ones,
  output logic [4:0]  f2_ones,
  output logic [4:0]  f3_ones,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_DWELL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_clear;
  logic              w_advance;
  logic              w_sample;
  logic              w_next_active;

  logic [3:0]  r_vec;
  logic        r_vec_valid;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_f1_map, r_f2_map, r_f3_map;
  logic [4:0]  r_f1_ones, r_f2_ones, r_f3_ones;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_clear      = 1'b0;
    w_advance    = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_next_state = S_SETTLE;
          w_next_cnt   = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_next_state = S_SAMPLE;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      S_SAMPLE: begin
        w_sample = 1'b1;
        if (r_vec == 4'hF) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_DWELL;
          w_next_cnt   = DWELL_LOAD;
        end
      end
      S_DWELL: begin
        // In step mode the counter is frozen; only a step pulse moves on.
        if (step_mode) begin
          if (step) w_advance = 1'b1;
        end else if (r_cnt == '0) begin
          w_advance = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_advance) begin
      w_next_state = S_SETTLE;
      w_next_cnt   = SETTLE_LOAD;
    end
  end

  assign w_next_active = (w_next_state == S_SETTLE) || (w_next_state == S_SAMPLE) ||
                         (w_next_state == S_DWELL);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_vec       <= 4'd0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_f1_map    <= 16'd0;
      r_f2_map    <= 16'd0;
      r_f3_map    <= 16'd0;
      r_f1_ones   <= 5'd0;
      r_f2_ones   <= 5'd0;
      r_f3_ones   <= 5'd0;
    end else begin
      r_vec_valid <= w_next_active;
      r_busy      <= w_next_active;
      r_done      <= (w_next_state == S_DONE);
      if (w_clear) begin
        r_vec     <= 4'd0;
        r_f1_map  <= 16'd0;
        r_f2_map  <= 16'd0;
        r_f3_map  <= 16'd0;
        r_f1_ones <= 5'd0;
        r_f2_ones <= 5'd0;
        r_f3_ones <= 5'd0;
      end else begin
        if (w_advance) r_vec <= r_vec + 4'd1;
        if (w_sample) begin
          r_f1_map[r_vec] <= func_in[0];
          r_f2_map[r_vec] <= func_in[1];
          r_f3_map[r_vec] <= func_in[2];
          r_f1_ones       <= r_f1_ones + {4'd0, func_in[0]};
          r_f2_ones       <= r_f2_ones + {4'd0, func_in[1]};
          r_f3_ones       <= r_f3_ones + {4'd0, func_in[2]};
        end
      end
    end
  end

  assign vec_out     = r_vec;
  assign vec_valid   = r_vec_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign f1_map      = r_f1_map;
  assign f2_map      = r_f2_map;
  assign f3_map      = r_f3_map;
  assign f1_ones     = r_f1_ones;
  assign f2_ones     = r_f2_ones;
  assign f3_ones     = r_f3_ones;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: table of free-run sweeps against a small
// function-unit model, plus hand-written reset, step-mode and ignored-input sequences.
module tb_truth_table_sequencer;

  localparam int DW  = 3;
  localparam int STL = 2;
  localparam int LAT = 16 * (STL + 1) + 15 * DW + 1;
  localparam int BUDGET = 2000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_DWELL  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic        clk = 1'b0;
  logic        rst, start, step_mode, step;
  logic [2:0]  func_in;
  logic [3:0]  vec_out;
  logic        vec_valid, busy, done;
  logic [15:0] f1_map, f2_map, f3_map;
  logic [4:0]  f1_ones, f2_ones, f3_ones;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // model mode: 0 = majority, 1 = f1 constant 1, 2 = f1 constant 0, 3 = majority with f3 = A1
  logic [1:0] model_mode;
  logic       garbage;
  int         age;
  logic [3:0] last_vec;
  logic       last_valid;
  logic       sb_on;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0]  mode;
    logic        garb;
    logic [15:0] f1m;
    logic [4:0]  f1o;
    logic [15:0] f2m;
    logic [4:0]  f2o;
    logic [15:0] f3m;
    logic [4:0]  f3o;
  } vec_t;

  vec_t tbl[5];

  truth_table_sequencer #(
    .DWELL_CYCLES(DW),
    .SETTLE_CYCLES(STL),
    .CNT_W(4)
  ) dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .start(start),
    .step_mode(step_mode),
    .step(step),
    .func_in(func_in),
    .vec_out(vec_out),
    .vec_valid(vec_valid),
    .busy(busy),
    .done(done),
    .f1_map(f1_map),
    .f2_map(f2_map),
    .f3_map(f3_map),
    .f1_ones(f1_ones),
    .f2_ones(f2_ones),
    .f3_ones(f3_ones),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model(input logic [1:0] m, input logic [3:0] a);
    logic f1, f2, f3;
    f1 = (a[2] & a[1]) | (a[2] & a[0]) | (a[1] & a[0]);
    if (m == 2'd1) f1 = 1'b1;
    if (m == 2'd2) f1 = 1'b0;
    f2 = a[3] & a[0];
    f3 = (m == 2'd3) ? a[1] : 1'b0;
    return {f3, f2, f1};
  endfunction

  // Garbage mode inverts the outputs for the first two cycles after a new vector.
  assign func_in = (garbage && age < 2) ? ~model(model_mode, vec_out) : model(model_mode, vec_out);

  always @(negedge clk) begin
    last_vec   <= vec_out;
    last_valid <= vec_valid;
    if (vec_out != last_vec || (vec_valid && !last_valid)) age <= 0;
    else if (age < 100) age <= age + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every SAMPLE cycle must present the next expected vector.
  always @(negedge clk) begin
    if (sb_on && dbg_state == ST_SAMPLE) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: unexpected sample of vec %0h", vec_out);
      end else begin
        check("sb_vec", 32'(vec_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic arm_sb();
    exp_q.delete();
    for (int v = 0; v < 16; v++) exp_q.push_back(4'(v));
    sb_on = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Counts from cycle 1 (already reached) until done is seen or the budget runs out.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_maps(input string tag, input logic [15:0] m1, input logic [4:0] o1,
                            input logic [15:0] m2, input logic [4:0] o2,
                            input logic [15:0] m3, input logic [4:0] o3);
    check({tag, "_f1_map"}, 32'(f1_map), 32'(m1));
    check({tag, "_f1_ones"}, 32'(f1_ones), 32'(o1));
    check({tag, "_f2_map"}, 32'(f2_map), 32'(m2));
    check({tag, "_f2_ones"}, 32'(f2_ones), 32'(o2));
    check({tag, "_f3_map"}, 32'(f3_map), 32'(m3));
    check({tag, "_f3_ones"}, 32'(f3_ones), 32'(o3));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_vec"}, 32'(vec_out), 32'd0);
    check({tag, "_ctl"}, 32'({vec_valid, busy, done}), 32'd0);
    check_maps(tag, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0, 5'd0);
  endtask

  initial begin
    int cyc;
    logic fired;
    rst = 1'b1; start = 1'b0; step = 1'b0; step_mode = 1'b0;
    model_mode = 2'd0; garbage = 1'b0; sb_on = 1'b0;
    age = 0; last_vec = 4'd0; last_valid = 1'b0;

    tbl[0] = '{mode: 2'd0, garb: 1'b0, f1m: 16'hE8E8, f1o: 5'd8,  f2m: 16'hAA00, f2o: 5'd4, f3m: 16'h0000, f3o: 5'd0};
    tbl[1] = '{mode: 2'd0, garb: 1'b1, f1m: 16'hE8E8, f1o: 5'd8,  f2m: 16'hAA00, f2o: 5'd4, f3m: 16'h0000, f3o: 5'd0};
    tbl[2] = '{mode: 2'd1, garb: 1'b0, f1m: 16'hFFFF, f1o: 5'd16, f2m: 16'hAA00, f2o: 5'd4, f3m: 16'h0000, f3o: 5'd0};
    tbl[3] = '{mode: 2'd2, garb: 1'b0, f1m: 16'h0000, f1o: 5'd0,  f2m: 16'hAA00, f2o: 5'd4, f3m: 16'h0000, f3o: 5'd0};
    tbl[4] = '{mode: 2'd3, garb: 1'b1, f1m: 16'hE8E8, f1o: 5'd8,  f2m: 16'hAA00, f2o: 5'd4, f3m: 16'hCCCC, f3o: 5'd8};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Free-run sweeps; each entry after the first restarts from DONE.
    for (int i = 0; i < 5; i++) begin
      model_mode = tbl[i].mode;
      garbage    = tbl[i].garb;
      arm_sb();
      pulse_start();
      check("cyc1_vec", 32'(vec_out), 32'd0);
      check("cyc1_ctl", 32'({vec_valid, busy, done}), 32'b110);
      check("cyc1_f1_map", 32'(f1_map), 32'd0);
      check("cyc1_f2_ones", 32'(f2_ones), 32'd0);
      wait_done(cyc);
      check("latency", 32'(cyc), 32'(LAT));
      check("done_ctl", 32'({vec_valid, busy, done}), 32'b001);
      check("done_vec", 32'(vec_out), 32'd15);
      check("done_state", 32'(dbg_state), 32'(ST_DONE));
      check_maps("table", tbl[i].f1m, tbl[i].f1o, tbl[i].f2m, tbl[i].f2o, tbl[i].f3m, tbl[i].f3o);
      check("sb_left", 32'(exp_q.size()), 32'd0);
      sb_on = 1'b0;
      repeat (5) @(negedge clk);
      check("done_hold_vec", 32'(vec_out), 32'd15);
      check("done_hold_map", 32'(f1_map), 32'(tbl[i].f1m));
    end
    garbage = 1'b0;

    // start during DWELL at vec 5 must be ignored.
    model_mode = 2'd0;
    pulse_start();
    fired = 1'b0;
    cyc = 1;
    while (!done && cyc < BUDGET) begin
      if (!fired && vec_out == 4'd5 && dbg_state == ST_DWELL) begin
        start = 1'b1;
        fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("ign_fired", 32'(fired), 32'd1);
    check("ign_latency", 32'(cyc), 32'(LAT));
    check_maps("ign", 16'hE8E8, 5'd8, 16'hAA00, 5'd4, 16'h0, 5'd0);

    // Reset at cycle 20 of a sweep clears everything immediately.
    model_mode = 2'd1;
    pulse_start();
    repeat (19) @(negedge clk);
    check("pre_rst_vec", 32'(vec_out), 32'd3);
    check("pre_rst_f1_map", 32'(f1_map), 32'h7);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk) rst = 1'b0;
    model_mode = 2'd0;
    arm_sb();
    pulse_start();
    check("rst_restart_vec", 32'(vec_out), 32'd0);
    wait_done(cyc);
    check("rst_restart_lat", 32'(cyc), 32'(LAT));
    check_maps("rst_restart", 16'hE8E8, 5'd8, 16'hAA00, 5'd4, 16'h0, 5'd0);
    check("sb_left_rst", 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;

    // Step mode: parked in DWELL at vec 0 until stepped.
    step_mode = 1'b1;
    arm_sb();
    pulse_start();
    repeat (1000) @(negedge clk);
    check("stp_park_vec", 32'(vec_out), 32'd0);
    check("stp_park_busy", 32'(busy), 32'd1);
    check("stp_park_state", 32'(dbg_state), 32'(ST_DWELL));
    check("stp_park_ones", 32'(f1_ones), 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      if (i == 4) begin
        // Extra step while still in SETTLE must not advance.
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        repeat (6) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      check("stp_vec", 32'(vec_out), 32'(i + 1));
    end
    check("stp_done", 32'({vec_valid, busy, done}), 32'b001);
    check_maps("stp", 16'hE8E8, 5'd8, 16'hAA00, 5'd4, 16'h0, 5'd0);
    check("sb_left_stp", 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    repeat (3) @(negedge clk);
    check("stp_extra_state", 32'(dbg_state), 32'(ST_DONE));
    check("stp_extra_vec", 32'(vec_out), 32'd15);
    check("stp_extra_map", 32'(f1_map), 32'hE8E8);

    // start+step together in IDLE: start wins, then switch to free-run mid-dwell.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) begin start = 1'b1; step = 1'b1; end
    @(negedge clk) begin start = 1'b0; step = 1'b0; end
    check("ss_state", 32'(dbg_state), 32'(ST_SETTLE));
    check("ss_vec", 32'(vec_out), 32'd0);
    check("ss_busy", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    check("ss_park_vec", 32'(vec_out), 32'd0);
    check("ss_park_state", 32'(dbg_state), 32'(ST_DWELL));
    step_mode = 1'b0;
    wait_done(cyc);
    check("ss_freerun_done", 32'(done), 32'd1);
    check_maps("ss", 16'hE8E8, 5'd8, 16'hAA00, 5'd4, 16'h0, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
